// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : CPU-side memory controller. Decodes a 16-bit byte address into
//               an external synchronous SRAM (addr[15]=0) or a small IO block
//               (addr[15]=1) holding an LED register, a free-running timer
//               with compare, and a sticky status register. Reads complete
//               with a fixed one-cycle latency. The last returned word is held
//               on rdata between completions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n         clock / asynchronous active-low reset
//   ren, wen           CPU read / write request
//   addr[15:0]         CPU byte address
//   wdata[31:0]        CPU write data (lane aligned)
//   wmask[3:0]         byte mask, wmask[3-i] enables wdata[8i+7:8i]
//   rdata[31:0]        read data (held between completions)
//   rd_valid           read-complete strobe, one cycle after the request
//   sram_ce/we         SRAM enable / write (combinational from CPU side)
//   sram_addr          SRAM word address
//   sram_wdata         SRAM write data
//   sram_be[3:0]       SRAM byte enables, sram_be[i] enables bits 8i+7:8i
//   sram_rdata[31:0]   SRAM read data, valid the cycle after a read enable
//   led[7:0]           LED register
//   timer_flag         sticky TIMER_COUNT==TIMER_CMP flag
//   bus_err            sticky flag: read and write requested together
// ============================================================================
module mem_ctrl #(
    parameter int SRAM_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ren,
    input  logic               wen,
    input  logic [15:0]        addr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wmask,
    output logic [31:0]        rdata,
    output logic               rd_valid,
    output logic               sram_ce,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    output logic [3:0]         sram_be,
    input  logic [31:0]        sram_rdata,
    output logic [7:0]         led,
    output logic               timer_flag,
    output logic               bus_err
);

    // IO word indices (addr[14:2]) within the IO half of the map
    localparam logic [12:0] c_IDX_LED    = 13'd0;
    localparam logic [12:0] c_IDX_COUNT  = 13'd1;
    localparam logic [12:0] c_IDX_CMP    = 13'd2;
    localparam logic [12:0] c_IDX_STATUS = 13'd3;

    logic [7:0]  r_led;
    logic [31:0] r_timer_count;
    logic [31:0] r_timer_cmp;
    logic        r_timer_flag;
    logic        r_bus_err;
    logic        r_rd_valid;
    logic        r_rd_is_io;
    logic [31:0] r_io_rdata;
    logic [31:0] r_rdata_hold;

    logic        w_is_io;
    logic [12:0] w_io_idx;
    logic [31:0] w_lane;
    logic        w_io_wr;
    logic        w_wr_led;
    logic        w_wr_count;
    logic        w_wr_cmp;
    logic        w_wr_status;
    logic        w_rd_accept;
    logic [31:0] w_io_rvalue;
    logic [31:0] w_count_inc;
    logic [31:0] w_count_next;
    logic [31:0] w_cmp_next;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    // Byte offset inside the word is meaningless for word-wide accesses
    assign w_unused_addr = ^addr[1:0];

    assign w_is_io  = addr[15];
    assign w_io_idx = addr[14:2];

    // SRAM side is a pure combinational pass-through of the CPU request
    assign sram_ce    = (ren | wen) & ~w_is_io;
    assign sram_we    = wen & ~w_is_io;
    assign sram_addr  = addr[SRAM_AW+1:2];
    assign sram_wdata = wdata;
    assign sram_be    = {wmask[0], wmask[1], wmask[2], wmask[3]};

    // Bit-level mask: wmask is MSB-first relative to byte lanes
    assign w_lane = {{8{wmask[0]}}, {8{wmask[1]}}, {8{wmask[2]}}, {8{wmask[3]}}};

    assign w_io_wr     = wen & w_is_io;
    assign w_wr_led    = w_io_wr & (w_io_idx == c_IDX_LED);
    assign w_wr_count  = w_io_wr & (w_io_idx == c_IDX_COUNT);
    assign w_wr_cmp    = w_io_wr & (w_io_idx == c_IDX_CMP);
    assign w_wr_status = w_io_wr & (w_io_idx == c_IDX_STATUS);

    // A simultaneous write wins; the read is dropped and flagged
    assign w_rd_accept = ren & ~wen;

    // CPU write bytes override the incremented count; other bytes still tick
    assign w_count_inc  = r_timer_count + 32'd1;
    assign w_count_next = w_wr_count ? ((w_count_inc & ~w_lane) | (wdata & w_lane))
                                     : w_count_inc;
    assign w_cmp_next   = (r_timer_cmp & ~w_lane) | (wdata & w_lane);

    always_comb begin
        w_io_rvalue = 32'd0;
        case (w_io_idx)
            c_IDX_LED:    w_io_rvalue = {24'd0, r_led};
            c_IDX_COUNT:  w_io_rvalue = r_timer_count;
            c_IDX_CMP:    w_io_rvalue = r_timer_cmp;
            c_IDX_STATUS: w_io_rvalue = {30'd0, r_bus_err, r_timer_flag};
            default:      w_io_rvalue = 32'd0;
        endcase
    end

    // SRAM data arrives in the completion cycle itself, so it is muxed in live
    assign w_rdata = r_rd_valid ? (r_rd_is_io ? r_io_rdata : sram_rdata) : r_rdata_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led         <= 8'd0;
            r_timer_count <= 32'd0;
            r_timer_cmp   <= 32'hFFFF_FFFF;
            r_timer_flag  <= 1'b0;
            r_bus_err     <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_is_io    <= 1'b0;
            r_io_rdata    <= 32'd0;
            r_rdata_hold  <= 32'd0;
        end else begin
            r_rd_valid    <= w_rd_accept;
            r_timer_count <= w_count_next;

            if (w_rd_accept) begin
                r_rd_is_io <= w_is_io;
                r_io_rdata <= w_io_rvalue;
            end

            if (r_rd_valid) begin
                r_rdata_hold <= w_rdata;
            end

            if (w_wr_led && wmask[3]) begin
                r_led <= wdata[7:0];
            end

            if (w_wr_cmp) begin
                r_timer_cmp <= w_cmp_next;
            end

            // Set has priority over a same-cycle write-1-to-clear
            if (r_timer_count == r_timer_cmp) begin
                r_timer_flag <= 1'b1;
            end else if (w_wr_status && wmask[3] && wdata[0]) begin
                r_timer_flag <= 1'b0;
            end

            if (ren && wen) begin
                r_bus_err <= 1'b1;
            end else if (w_wr_status && wmask[3] && wdata[1]) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    assign rdata      = w_rdata;
    assign rd_valid   = r_rd_valid;
    assign led        = r_led;
    assign timer_flag = r_timer_flag;
    assign bus_err    = r_bus_err;

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The module SHALL have one parameter: SRAM_AW, default 12, SRAM word-address width (SRAM size 4*2^SRAM_AW bytes).
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ren  in  1  CPU read request
- wen  in  1  CPU write request
- addr  in  16  CPU byte address
- wdata  in  32  CPU write data, already lane-aligned
- wmask  in  4  CPU byte mask; wmask[3-i] enables wdata[8i+7:8i]
- rdata  out  32  read data to CPU
- rd_valid  out  1  read-complete strobe
- sram_ce  out  1  SRAM enable
- sram_we  out  1  SRAM write
- sram_addr  out  SRAM_AW  SRAM word address
- sram_wdata  out  32  SRAM write data
- sram_be  out  4  SRAM byte enables; sram_be[i] enables bits 8i+7:8i
- sram_rdata  in  32  SRAM read data, valid the cycle after a read enable
- led  out  8  LED register
- timer_flag  out  1  sticky timer-match flag
- bus_err  out  1  sticky protocol-error flag

Function
REQ-003 Decode: addr[15]=0 selects SRAM; addr[15]=1 selects IO.
REQ-004 SRAM drive SHALL be combinational from CPU inputs:
- sram_ce = (ren|wen) & !addr[15]
- sram_we = wen & !addr[15]
- sram_addr = addr[SRAM_AW+1:2]; address bits above that range alias.
- sram_wdata = wdata
- sram_be[i] = wmask[3-i]
REQ-005 IO map (word-aligned, addr[1:0] ignored):
- 0x8000 LED, bits 7:0 R/W
- 0x8004 TIMER_COUNT, R/W
- 0x8008 TIMER_CMP, R/W
- 0x800C STATUS: bit0 timer_flag (write 1 clears), bit1 bus_err (write 1 clears)
- Other IO addresses read as 0; writes to them are ignored.
REQ-006 IO writes SHALL take effect at the clock edge where wen=1; each byte lane updates only when its wmask bit is set.
REQ-007 Read latency SHALL be exactly 1 cycle. When ren=1 at edge N, rd_valid=1 during cycle N+1 and rdata equals the addressed word during that cycle.
REQ-008 In a completion cycle, rdata = sram_rdata for an SRAM read, or the IO value registered at edge N for an IO read.
REQ-009 The value returned in a completion cycle SHALL be captured into a hold register. In every non-completion cycle, rdata equals that hold register (last read value held indefinitely).
REQ-010 Back-to-back reads (ren high for consecutive cycles) SHALL each complete one cycle later, giving one rd_valid per request cycle.
REQ-011 ren=1 and wen=1 in the same cycle: the write is performed, the read is dropped (no rd_valid), and bus_err is set.
REQ-012 TIMER_COUNT SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0.
- A CPU write to TIMER_COUNT replaces the increment in that cycle; unmasked bytes keep their incremented value.
REQ-013 timer_flag SHALL set at the edge after a cycle in which TIMER_COUNT==TIMER_CMP.
- If set and clear occur in the same cycle, set wins.
REQ-014 A read of TIMER_COUNT SHALL return the count value present in the request cycle.
REQ-015 led SHALL reflect the LED register directly.

Reset
REQ-016 While rst_n=0, all registers SHALL take these values:
- rd_valid=0, hold register=0
- led=0
- TIMER_COUNT=0, TIMER_CMP=0xFFFFFFFF
- timer_flag=0, bus_err=0
- any pending read cancelled
REQ-017 A read in flight when reset asserts SHALL NOT produce rd_valid after reset releases.
REQ-018 During reset, the SRAM drive outputs SHALL still follow REQ-004 combinationally; the CPU holds ren=wen=0 then.

Verification
REQ-019 SRAM write then read:
- Stimulus: wen at 0x0010, wdata=0xDEADBEEF, wmask=1111; then ren at 0x0010.
- Response: sram_be=1111 and sram_addr=4 on the write; rd_valid one cycle after ren with rdata=0xDEADBEEF; rdata still 0xDEADBEEF 5 cycles later.
REQ-020 Byte lane mapping:
- Stimulus: wen at 0x0013, wmask=0001, wdata=0xAB000000.
- Response: sram_be=1000; a subsequent read shows only bits 31:24 changed.
REQ-021 Timer match:
- Stimulus: write TIMER_CMP=20 and TIMER_COUNT=10.
- Response: timer_flag rises 11 cycles after the count write; writing STATUS=1 clears it; the count wraps to 0 after 0xFFFFFFFF.
REQ-022 Protocol error:
- Stimulus: ren=wen=1 at 0x8000, wdata=0x5A.
- Response: led=0x5A, no rd_valid, bus_err=1; writing STATUS=2 clears bus_err.
REQ-023 Reset mid-read:
- Stimulus: ren at 0x8004 then rst_n=0 in the next cycle.
- Response: rd_valid=0, rdata=0, led=0, TIMER_CMP reads 0xFFFFFFFF after release.
REQ-024 Streaming reads:
- Stimulus: ren held for 4 cycles at 0x0000, 0x0004, 0x0008, 0x8000.
- Response: 4 consecutive rd_valid pulses with matching data in order.
